// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// with memory handshake, wait timeout, illegal-opcode trap and retire counter.
//
// state    | meaning
// FETCH    | read instruction, PC+4 into PC on mem_ready
// DECODE   | read registers, branch target into ALUOut
// MEMADR   | compute load/store address
// MEMREAD  | load data from memory
// MEMWB    | write loaded data to rd
// MEMWRITE | store data to memory
// EXECR    | R-type ALU operation
// EXECI    | I-type ALU operation
// ALUWB    | write ALUOut to rd
// BEQ      | compare and conditionally load PC
// JAL      | load PC with jump target, PC+4 into ALUOut
// TRAP     | halted on illegal opcode or memory timeout
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [6:0]       i_op,
    input  logic             i_mem_ready,
    output logic             o_mem_req,
    output logic             o_adr_src,
    output logic             o_mem_write,
    output logic             o_ir_write,
    output logic             o_pc_write,
    output logic             o_branch,
    output logic             o_reg_write,
    output logic [1:0]       o_alu_src_a,
    output logic [1:0]       o_alu_src_b,
    output logic [1:0]       o_alu_op,
    output logic [1:0]       o_result_src,
    output logic [1:0]       o_imm_src,
    output logic [3:0]       o_state,
    output logic             o_illegal_op,
    output logic             o_mem_fault,
    output logic [CNT_W-1:0] o_instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // The counter only needs to reach MEM_TIMEOUT-1: the cycle that would make it
    // MEM_TIMEOUT is the one that redirects to TRAP.
    localparam bit TMO_EN   = (MEM_TIMEOUT > 0);
    localparam int WAIT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int TMO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [WAIT_W-1:0] WAIT_LAST = TMO_LAST[WAIT_W-1:0];

    state_t             r_state;
    state_t             w_next;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_illegal_op;
    logic               r_mem_fault;
    logic [CNT_W-1:0]   r_instret;

    logic               w_waiting;
    logic               w_timeout;
    logic               w_illegal;
    logic               w_retire;
    logic               w_mem_req;
    logic               w_adr_src;
    logic               w_mem_write;
    logic               w_ir_write;
    logic               w_pc_write;
    logic               w_branch;
    logic               w_reg_write;
    logic [1:0]         w_alu_src_a;
    logic [1:0]         w_alu_src_b;
    logic [1:0]         w_alu_op;
    logic [1:0]         w_result_src;
    logic [1:0]         w_imm_src;

    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                        (r_state == S_MEMWRITE)) && !i_mem_ready;
    assign w_timeout = TMO_EN && w_waiting && (r_wait_cnt == WAIT_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_illegal    = 1'b0;
        w_mem_req    = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_result_src = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                if (i_mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (i_op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    default: begin
                        w_next    = S_TRAP;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_next      = (i_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                if (i_mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
                if (i_mem_ready) w_next = S_FETCH;
            end
            S_EXECR: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end
            S_EXECI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BEQ: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b01;
                w_branch    = 1'b1;
                w_next      = S_FETCH;
            end
            S_JAL: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_write  = 1'b1;
                w_next      = S_ALUWB;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_TRAP;
            end
        endcase
        // A timed-out access must not leave a half-done request or write behind.
        if (w_timeout) begin
            w_next      = S_TRAP;
            w_mem_req   = 1'b0;
            w_mem_write = 1'b0;
            w_ir_write  = 1'b0;
            w_pc_write  = 1'b0;
            w_branch    = 1'b0;
            w_reg_write = 1'b0;
        end
    end

    always_comb begin
        w_imm_src = 2'b00;
        case (i_op)
            OP_SW:   w_imm_src = 2'b01;
            OP_BEQ:  w_imm_src = 2'b10;
            OP_JAL:  w_imm_src = 2'b11;
            default: w_imm_src = 2'b00;
        endcase
    end

    // Only MEMWB/MEMWRITE/ALUWB/BEQ can reach FETCH from another state.
    assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wait_cnt   <= '0;
            r_illegal_op <= 1'b0;
            r_mem_fault  <= 1'b0;
            r_instret    <= '0;
        end else begin
            if (!TMO_EN || !w_waiting || (w_next != r_state)) begin
                r_wait_cnt <= '0;
            end else begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if (w_illegal) r_illegal_op <= 1'b1;
            if (w_timeout) r_mem_fault  <= 1'b1;
            if (w_retire)  r_instret    <= r_instret + CNT_W'(1);
        end
    end

    // Reset is async, so gating here keeps requests and writes low for the whole pulse.
    assign o_mem_req    = w_mem_req   & ~i_reset;
    assign o_mem_write  = w_mem_write & ~i_reset;
    assign o_ir_write   = w_ir_write  & ~i_reset;
    assign o_pc_write   = w_pc_write  & ~i_reset;
    assign o_branch     = w_branch    & ~i_reset;
    assign o_reg_write  = w_reg_write & ~i_reset;
    assign o_adr_src    = w_adr_src;
    assign o_alu_src_a  = w_alu_src_a;
    assign o_alu_src_b  = w_alu_src_b;
    assign o_alu_op     = w_alu_op;
    assign o_result_src = w_result_src;
    assign o_imm_src    = w_imm_src;
    assign o_state      = r_state;
    assign o_illegal_op = r_illegal_op;
    assign o_mem_fault  = r_mem_fault;
    assign o_instret    = r_instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state and control
// outputs are queued with the stimulus and compared as the FSM steps.
module tb_multicycle_control;

    localparam int CNT_W = 3;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic             clk = 1'b0;
    logic             reset;
    logic [6:0]       op;
    logic             mem_ready;
    logic             mem_req, adr_src, mem_write, ir_write, pc_write, branch, reg_write;
    logic [1:0]       alu_src_a, alu_src_b, alu_op, result_src, imm_src;
    logic [3:0]       state;
    logic             illegal_op, mem_fault;
    logic [CNT_W-1:0] instret;

    int n_checks = 0;
    int n_errors = 0;
    int n_wr     = 0;

    typedef struct packed {
        logic [6:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [14:0] out;
        logic [14:0] mask;
    } sb_t;

    sb_t sb[$];

    multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_reset(reset), .i_op(op), .i_mem_ready(mem_ready),
        .o_mem_req(mem_req), .o_adr_src(adr_src), .o_mem_write(mem_write),
        .o_ir_write(ir_write), .o_pc_write(pc_write), .o_branch(branch),
        .o_reg_write(reg_write), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
        .o_alu_op(alu_op), .o_result_src(result_src), .o_imm_src(imm_src),
        .o_state(state), .o_illegal_op(illegal_op), .o_mem_fault(mem_fault),
        .o_instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    // {mem_req, adr_src, mem_write, ir_write, pc_write, branch, reg_write, a, b, alu_op, result_src}
    function automatic logic [14:0] exp_out(input logic [3:0] st, input logic rdy);
        case (st)
            4'd0:    exp_out = {1'b1, 1'b0, 1'b0, rdy, rdy, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10};
            4'd1:    exp_out = {7'b0, 2'b01, 2'b01, 2'b00, 2'b00};
            4'd2:    exp_out = {7'b0, 2'b10, 2'b01, 2'b00, 2'b00};
            4'd3:    exp_out = {1'b1, 1'b1, 5'b0, 8'b0};
            4'd4:    exp_out = {6'b0, 1'b1, 6'b0, 2'b01};
            4'd5:    exp_out = {1'b1, 1'b1, 1'b1, 4'b0, 8'b0};
            4'd6:    exp_out = {7'b0, 2'b10, 2'b00, 2'b10, 2'b00};
            4'd7:    exp_out = {7'b0, 2'b10, 2'b01, 2'b10, 2'b00};
            4'd8:    exp_out = {6'b0, 1'b1, 8'b0};
            4'd9:    exp_out = {5'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00};
            4'd10:   exp_out = {4'b0, 1'b1, 2'b0, 2'b01, 2'b10, 2'b00, 2'b00};
            default: exp_out = 15'b0;
        endcase
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        case (o)
            OP_SW:   exp_imm = 2'b01;
            OP_BEQ:  exp_imm = 2'b10;
            OP_JAL:  exp_imm = 2'b11;
            default: exp_imm = 2'b00;
        endcase
    endfunction

    task automatic push(input logic [6:0] o, input logic rdy, input logic [3:0] st);
        sb_t e;
        e.op = o; e.rdy = rdy; e.st = st;
        e.out = exp_out(st, rdy); e.mask = 15'h7fff;
        sb.push_back(e);
    endtask

    task automatic push_instr(input logic [6:0] o);
        case (o)
            OP_I:    begin push(o,1,0); push(o,1,1); push(o,1,7); push(o,1,8); end
            OP_R:    begin push(o,1,0); push(o,1,1); push(o,1,6); push(o,1,8); end
            OP_LW:   begin push(o,1,0); push(o,1,1); push(o,1,2); push(o,1,3); push(o,1,4); end
            OP_SW:   begin push(o,1,0); push(o,1,1); push(o,1,2); push(o,1,5); end
            OP_BEQ:  begin push(o,1,0); push(o,1,1); push(o,1,9); end
            default: begin push(o,1,0); push(o,1,1); push(o,1,10); push(o,1,8); end
        endcase
    endtask

    // Called at the start of a cycle (just after a falling edge); returns at the next one.
    task automatic run_sb();
        sb_t e;
        logic [14:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op;
            mem_ready = e.rdy;
            #1;
            obs = {mem_req, adr_src, mem_write, ir_write, pc_write, branch, reg_write,
                   alu_src_a, alu_src_b, alu_op, result_src};
            if (reg_write === 1'b1) n_wr++;
            n_checks++;
            if (state !== e.st) begin
                n_errors++;
                $display("FAIL state_seq: state=%0d expected %0d (op=%b t=%0t)", state, e.st, e.op, $time);
            end
            n_checks++;
            if ((obs & e.mask) !== (e.out & e.mask)) begin
                n_errors++;
                $display("FAIL ctrl_out: got %b expected %b in state %0d (t=%0t)", obs & e.mask, e.out & e.mask, e.st, $time);
            end
            n_checks++;
            if (imm_src !== exp_imm(e.op)) begin
                n_errors++;
                $display("FAIL imm_src: got %b expected %b for op %b", imm_src, exp_imm(e.op), e.op);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        op = OP_I;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({state, instret, illegal_op, mem_fault} !== {4'd0, {CNT_W{1'b0}}, 2'b00}) begin
            n_errors++;
            $display("FAIL reset_state: state=%0d instret=%0d ill=%b flt=%b expected 0/0/0/0", state, instret, illegal_op, mem_fault);
        end
        n_checks++;
        if ({mem_req, mem_write, ir_write, pc_write, branch, reg_write} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_enables: got %b expected 000000", {mem_req, mem_write, ir_write, pc_write, branch, reg_write});
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_errors++;
            $display("FAIL first_fetch: mem_req=%b expected 1", mem_req);
        end
    endtask

    task automatic test_program();
        push_instr(OP_I); push_instr(OP_R); push_instr(OP_LW);
        push_instr(OP_SW); push_instr(OP_BEQ); push_instr(OP_JAL);
        run_sb();
        #1;
        n_checks++;
        if (instret !== CNT_W'(6)) begin
            n_errors++;
            $display("FAIL program_instret: got %0d expected 6", instret);
        end
    endtask

    task automatic test_lw_wait();
        n_wr = 0;
        push(OP_LW, 1, 0); push(OP_LW, 0, 1); push(OP_LW, 0, 2);
        push(OP_LW, 0, 3); push(OP_LW, 0, 3); push(OP_LW, 0, 3); push(OP_LW, 1, 3);
        push(OP_LW, 0, 4);
        run_sb();
        #1;
        n_checks++;
        if (n_wr !== 1) begin
            n_errors++;
            $display("FAIL lw_wait_regwrite: pulses=%0d expected 1", n_wr);
        end
        n_checks++;
        if (state !== 4'd0 || instret !== CNT_W'(7)) begin
            n_errors++;
            $display("FAIL lw_wait_retire: state=%0d instret=%0d expected 0/7", state, instret);
        end
    endtask

    task automatic test_timeout();
        sb_t e;
        test_reset();
        push(OP_I, 0, 0); push(OP_I, 0, 0); push(OP_I, 0, 0);
        e.op = OP_I; e.rdy = 0; e.st = 0; e.out = exp_out(4'd0, 1'b0); e.mask = 15'h3fff;
        sb.push_back(e);
        push(OP_I, 0, 15); push(OP_I, 1, 15); push(OP_I, 0, 15);
        run_sb();
        #1;
        n_checks++;
        if ({mem_fault, illegal_op, mem_req, ir_write} !== 4'b1000) begin
            n_errors++;
            $display("FAIL timeout_flags: flt/ill/req/irw=%b expected 1000", {mem_fault, illegal_op, mem_req, ir_write});
        end
    endtask

    task automatic test_illegal();
        test_reset();
        push(OP_BAD, 1, 0); push(OP_BAD, 1, 1);
        for (int i = 0; i < 20; i++) push(OP_BAD, i[0], 15);
        run_sb();
        #1;
        n_checks++;
        if ({illegal_op, mem_fault} !== 2'b10 || instret !== '0) begin
            n_errors++;
            $display("FAIL illegal_flags: ill=%b flt=%b instret=%0d expected 1/0/0", illegal_op, mem_fault, instret);
        end
    endtask

    task automatic test_reset_midwrite();
        test_reset();
        push_instr(OP_BEQ);
        push(OP_SW, 1, 0); push(OP_SW, 1, 1); push(OP_SW, 1, 2); push(OP_SW, 0, 5); push(OP_SW, 0, 5);
        run_sb();
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (mem_write !== 1'b1 || state !== 4'd5 || instret !== CNT_W'(1)) begin
            n_errors++;
            $display("FAIL midwrite_pre: mem_write=%b state=%0d instret=%0d expected 1/5/1", mem_write, state, instret);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_write, mem_req, reg_write} !== 3'b000 || state !== 4'd0 || instret !== '0 ||
            {illegal_op, mem_fault} !== 2'b00) begin
            n_errors++;
            $display("FAIL midwrite_abort: wr/req/rw=%b state=%0d instret=%0d expected 000/0/0",
                     {mem_write, mem_req, reg_write}, state, instret);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        test_reset();
        for (int i = 0; i < 9; i++) push_instr(OP_BEQ);
        run_sb();
        #1;
        n_checks++;
        if (instret !== CNT_W'(1) || state !== 4'd0) begin
            n_errors++;
            $display("FAIL beq_wrap: instret=%0d state=%0d expected 1/0", instret, state);
        end
    endtask

    initial begin
        reset = 1'b1;
        mem_ready = 1'b0;
        op = '0;
        test_reset();
        test_program();
        test_lw_wait();
        test_timeout();
        test_illegal();
        test_reset_midwrite();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
